// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the FSM state encoding, the NOP word, the word-alignment mask
// and the default instruction memory depth.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } ifu_state_e;

    localparam logic [31:0] IFU_NOP       = 32'h0000_0000;
    localparam logic [31:0] IFU_WORD_MASK = 32'hFFFF_FFFC;
    localparam int unsigned IFU_MEM_WORDS = 128;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register for the instruction fetch unit.
// Ports:
//   Clk, Reset      - clock, asynchronous active-low reset
//   load_i          - step PC by 4 (fetch advance)
//   redirect_i      - load the word-aligned target (wins over load_i)
//   target_i        - redirect byte address
//   pc_o            - current PC
//   pc_plus4_o      - PC + 4, modulo 2^32
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q, pc_d;

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i)  pc_d = target_i & IFU_WORD_MASK;
        else if (load_i) pc_d = pc_plus4_o;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the word address to a combinational
// instruction memory and captures the returned word plus PC+4 into an
// IF/ID register offered to decode through a valid/ready handshake.
// Ports:
//   Clk, Reset       - clock, asynchronous active-low reset
//   Address          - byte address to instruction memory (= PC)
//   Instruction      - memory read data for Address, same cycle
//   BranchTaken      - redirect request; BranchTarget is its byte address
//   Halt             - stop fetching
//   OutValid/OutReady- IF/ID handshake
//   InstrOut         - fetched instruction
//   PCPlus4Out       - fetched instruction address + 4
//   AddrFault        - sticky out-of-range fetch flag (IFU_BOUNDS_CHECK_EN only)
// Optional feature macro: IFU_BOUNDS_CHECK_EN
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = IFU_MEM_WORDS
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Halt,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] InstrOut,
`ifdef IFU_BOUNDS_CHECK_EN
    output logic [31:0] PCPlus4Out,
    output logic        AddrFault
`else
    output logic [31:0] PCPlus4Out
`endif
);

    ifu_state_e  state_q;
    logic        valid_q;
    logic [31:0] instr_q, pcp4_q;
    logic [31:0] pc, pc_plus4;
    logic        advance, redirect;
    logic [31:0] fetch_word;

    // Redirects are ignored during the single boot cycle.
    assign redirect = BranchTaken && (state_q != ST_BOOT);
    assign advance  = (state_q == ST_RUN) && !Halt && (!valid_q || OutReady);

    program_counter #(.RESET_PC(RESET_PC)) u_pc (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (advance),
        .redirect_i (redirect),
        .target_i   (BranchTarget),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;
    logic fault_q;
    logic oor;
    assign oor        = (pc >= MEM_BYTES);
    assign fetch_word = oor ? IFU_NOP : Instruction;
    assign AddrFault  = fault_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)             fault_q <= 1'b0;
        else if (advance && oor && !redirect) fault_q <= 1'b1;
    end
`else
    // Out-of-range PCs simply alias onto memory via Address[8:2].
    assign fetch_word = Instruction;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_BOOT;
            valid_q <= 1'b0;
            instr_q <= IFU_NOP;
            pcp4_q  <= 32'h0;
        end else if (redirect) begin
            // Redirect discards the held entry even if decode takes it now.
            state_q <= ST_RUN;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT:   state_q <= ST_RUN;
                ST_RUN:    if (Halt) state_q <= ST_HALTED;
                default:   state_q <= state_q;
            endcase
            if (advance) begin
                valid_q <= 1'b1;
                instr_q <= fetch_word;
                pcp4_q  <= pc_plus4;
            end else if (valid_q && OutReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Address    = pc;
    assign OutValid   = valid_q;
    assign InstrOut   = instr_q;
    assign PCPlus4Out = pcp4_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address, Instruction, BranchTarget, InstrOut, PCPlus4Out;
    logic        BranchTaken, Halt, OutValid, OutReady;
`ifdef IFU_BOUNDS_CHECK_EN
    logic        AddrFault;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    // Memory model: word i holds i*3, indexed by Address[8:2].
    assign Instruction = 32'(Address[8:2]) * 32'd3;

    instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(128)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Address      (Address),
        .Instruction  (Instruction),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Halt         (Halt),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .InstrOut     (InstrOut),
`ifdef IFU_BOUNDS_CHECK_EN
        .PCPlus4Out   (PCPlus4Out),
        .AddrFault    (AddrFault)
`else
        .PCPlus4Out   (PCPlus4Out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] p4, input logic [31:0] addr);
        chk({tag, ".valid"}, 32'(OutValid), 32'(v));
        chk({tag, ".instr"}, InstrOut, ins);
        chk({tag, ".pcp4"},  PCPlus4Out, p4);
        chk({tag, ".addr"},  Address, addr);
    endtask

    initial begin
        Reset = 1'b0; OutReady = 1'b1; BranchTaken = 1'b0;
        BranchTarget = 32'h0; Halt = 1'b0;
        #12;
        chk_out("reset", 1'b0, 32'd0, 32'd0, 32'h0);
`ifdef IFU_BOUNDS_CHECK_EN
        chk("reset.fault", 32'(AddrFault), 32'd0);
`endif
        @(negedge Clk); Reset = 1'b1;

        // Boot bubble, then 0, 3 streaming
        tick(); chk_out("boot", 1'b0, 32'd0, 32'd0, 32'h0);
        tick(); chk_out("f0",   1'b1, 32'd0, 32'd4, 32'h4);
        tick(); chk_out("f1",   1'b1, 32'd3, 32'd8, 32'h8);

        // Backpressure holds everything
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 1'b1, 32'd3, 32'd8, 32'h8);
        end
        OutReady = 1'b1;
        tick(); chk_out("f2", 1'b1, 32'd6, 32'd12, 32'hC);

        // Redirect while an entry is held: flushed, one bubble
        OutReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h41;
        tick(); chk_out("br.bubble", 1'b0, 32'd6, 32'd12, 32'h40);
        BranchTaken = 1'b0; OutReady = 1'b1;
        tick(); chk_out("br.tgt", 1'b1, 32'd48, 32'h44, 32'h44);

        // Move to 0x0C so the held entry sits while PC=0x10
        BranchTaken = 1'b1; BranchTarget = 32'hC;
        tick(); chk_out("br2.bubble", 1'b0, 32'd48, 32'h44, 32'hC);
        BranchTaken = 1'b0;
        tick(); chk_out("br2.tgt", 1'b1, 32'd9, 32'h10, 32'h10);

        // Halt with entry held: stays offered, no new fetch
        Halt = 1'b1; OutReady = 1'b0;
        tick(); chk_out("halt.hold", 1'b1, 32'd9, 32'h10, 32'h10);
        OutReady = 1'b1;
        tick(); chk_out("halt.drain", 1'b0, 32'd9, 32'h10, 32'h10);
        tick(); chk_out("halt.idle",  1'b0, 32'd9, 32'h10, 32'h10);

        // Branch with Halt still high: branch wins
        BranchTaken = 1'b1; BranchTarget = 32'h20;
        tick(); chk_out("unhalt.bubble", 1'b0, 32'd9, 32'h10, 32'h20);
        BranchTaken = 1'b0; Halt = 1'b0;
        tick(); chk_out("unhalt.tgt", 1'b1, 32'd24, 32'h24, 32'h24);

        // Last word and past the end
        BranchTaken = 1'b1; BranchTarget = 32'h1FC;
        tick(); chk_out("end.bubble", 1'b0, 32'd24, 32'h24, 32'h1FC);
        BranchTaken = 1'b0;
        tick(); chk_out("end.last", 1'b1, 32'd381, 32'h200, 32'h200);
`ifdef IFU_BOUNDS_CHECK_EN
        chk("end.last.fault", 32'(AddrFault), 32'd0);
`endif
        tick(); chk_out("end.oor", 1'b1, 32'd0, 32'h204, 32'h204);
`ifdef IFU_BOUNDS_CHECK_EN
        chk("end.oor.fault", 32'(AddrFault), 32'd1);
`endif

        // PC+4 wraps modulo 2^32
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFF;
        tick(); chk_out("wrap.bubble", 1'b0, 32'd0, 32'h204, 32'hFFFF_FFFC);
        BranchTaken = 1'b0;
`ifdef IFU_BOUNDS_CHECK_EN
        tick(); chk_out("wrap", 1'b1, 32'd0, 32'h0, 32'h0);
        chk("wrap.fault", 32'(AddrFault), 32'd1);
`else
        tick(); chk_out("wrap", 1'b1, 32'd381, 32'h0, 32'h0);
`endif
        tick(); chk_out("wrap.next", 1'b1, 32'd0, 32'h4, 32'h4);

        // Asynchronous reset mid-stream
        #2 Reset = 1'b0;
        #1 chk_out("areset", 1'b0, 32'd0, 32'd0, 32'h0);
`ifdef IFU_BOUNDS_CHECK_EN
        chk("areset.fault", 32'(AddrFault), 32'd0);
`endif
        @(negedge Clk); Reset = 1'b1;

        // Redirect during BOOT is ignored
        BranchTaken = 1'b1; BranchTarget = 32'h80;
        tick(); chk_out("boot.br", 1'b0, 32'd0, 32'd0, 32'h0);
        BranchTaken = 1'b0;
        tick(); chk_out("boot.f0", 1'b1, 32'd0, 32'd4, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
